// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory bus arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, D_BUS, I_BUS)
//   - F3_*        : RV32I funct3 size/sign codes carried on d_op
//   - *_W, LANES  : lane widths of the 32-bit Wishbone data path
//   - word_align  : clears the byte offset of an address
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      D_BUS = 2'd1,
      I_BUS = 2'd2
   } arb_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int BYTE_W = 8;
   localparam int HALF_W = 16;
   localparam int WORD_W = 32;
   localparam int LANES  = WORD_W / BYTE_W;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane steering between the core and a 32-bit bus.
//   Store side:
//     i_st_op     funct3 size code of the store
//     i_st_lo     byte offset (addr[1:0])
//     i_st_wdata  unaligned store data from the core
//     o_sel       byte-lane select (0001/0011/1111 shifted by offset, 4 bits)
//     o_st_data   byte/half replicated across all lanes, word passed through
//   Load side:
//     i_ld_op     funct3 size/sign code of the load
//     i_ld_lo     byte offset (addr[1:0])
//     i_ld_raw    raw bus word
//     o_ld_data   selected lane shifted down, sign/zero extended
// -----------------------------------------------------------------------------
module lsu_align
   import mem_arb_pkg::*;
(
   input  logic [2:0]        i_st_op,
   input  logic [1:0]        i_st_lo,
   input  logic [WORD_W-1:0] i_st_wdata,
   output logic [LANES-1:0]  o_sel,
   output logic [WORD_W-1:0] o_st_data,
   input  logic [2:0]        i_ld_op,
   input  logic [1:0]        i_ld_lo,
   input  logic [WORD_W-1:0] i_ld_raw,
   output logic [WORD_W-1:0] o_ld_data
);

   logic [LANES-1:0]  w_mask;
   logic [WORD_W-1:0] w_shifted;
   logic [HALF_W-1:0] w_lane;

   // NOTE: every signal written in an always_comb gets a default on its first
   // line so that no path leaves it unassigned, which would infer a latch.
   always_comb begin
      w_mask    = 4'b1111;
      o_st_data = i_st_wdata;
      case (i_st_op)
         F3_B, F3_BU: begin
            w_mask    = 4'b0001;
            o_st_data = {LANES{i_st_wdata[BYTE_W-1:0]}};
         end
         F3_H, F3_HU: begin
            w_mask    = 4'b0011;
            o_st_data = {2{i_st_wdata[HALF_W-1:0]}};
         end
         default: ;
      endcase
   end

   // Misaligned halves/words simply lose the lanes that fall off the top.
   assign o_sel = w_mask << i_st_lo;

   // Only the low half of the shifted word can ever reach a sub-word result.
   assign w_shifted = i_ld_raw >> {i_ld_lo, 3'b000};
   assign w_lane    = w_shifted[HALF_W-1:0];

   always_comb begin
      o_ld_data = i_ld_raw;
      case (i_ld_op)
         F3_B:    o_ld_data = {{(WORD_W-BYTE_W){w_lane[BYTE_W-1]}}, w_lane[BYTE_W-1:0]};
         F3_BU:   o_ld_data = {{(WORD_W-BYTE_W){1'b0}}, w_lane[BYTE_W-1:0]};
         F3_H:    o_ld_data = {{(WORD_W-HALF_W){w_lane[HALF_W-1]}}, w_lane};
         F3_HU:   o_ld_data = {{(WORD_W-HALF_W){1'b0}}, w_lane};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one Wishbone classic master between the core's instruction-fetch and
// data ports. One transaction outstanding at a time; within a pipeline slot the
// data access goes first (it belongs to the older instruction), then the fetch.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   i_req, i_addr / i_rdata      fetch request, word address / held instruction
//   d_req, d_we, d_op, d_addr,
//   d_wdata / d_rdata            data request / held, extended load result
//   stall                        high while a request of this slot is unserved
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_sel_o, wb_adr_o, wb_dat_o Wishbone master outputs
//   wb_dat_i, wb_ack_i           Wishbone slave response
//   bus_err                      one-cycle pulse when a transaction times out
//
// Configuration
//   ARB_TIMEOUT_EN  defined: a transaction with no ack after TIMEOUT_CYCLES bus
//                   cycles is abandoned, completes with a zero result and
//                   pulses bus_err. Undefined: wait for ack forever.
// -----------------------------------------------------------------------------
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [WORD_W-1:0] i_addr,
   output logic [WORD_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_op,
   input  logic [WORD_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              stall,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [LANES-1:0]  wb_sel_o,
   output logic [WORD_W-1:0] wb_adr_o,
   output logic [WORD_W-1:0] wb_dat_o,
   input  logic [WORD_W-1:0] wb_dat_i,
   input  logic              wb_ack_i,
   output logic              bus_err
);

   arb_state_t        r_state;
   arb_state_t        w_next_state;

   logic              r_d_done;
   logic              r_i_done;
   logic              r_discard;
   logic              r_we;
   logic [LANES-1:0]  r_sel;
   logic [WORD_W-1:0] r_adr;
   logic [WORD_W-1:0] r_dat;
   logic [2:0]        r_ld_op;
   logic [1:0]        r_ld_lo;
   logic [WORD_W-1:0] r_i_rdata;
   logic [WORD_W-1:0] r_d_rdata;

   logic              w_busy;
   logic              w_start_d;
   logic              w_start_i;
   logic              w_done;
   logic              w_keep;
   logic              w_stall_raw;
   logic              w_advance;
   logic              w_timeout;
   logic [LANES-1:0]  w_sel;
   logic [WORD_W-1:0] w_st_data;
   logic [WORD_W-1:0] w_ld_data;

   lsu_align u_lsu_align (
      .i_st_op    (d_op),
      .i_st_lo    (d_addr[1:0]),
      .i_st_wdata (d_wdata),
      .o_sel      (w_sel),
      .o_st_data  (w_st_data),
      .i_ld_op    (r_ld_op),
      .i_ld_lo    (r_ld_lo),
      .i_ld_raw   (wb_dat_i),
      .o_ld_data  (w_ld_data)
   );

   assign w_busy = (r_state != IDLE);
   assign w_done = w_busy & (wb_ack_i | w_timeout);

   // Stall is gated by reset so the pipeline sees a quiet arbiter while
   // reset_n is low, even if the core still holds a request.
   assign w_stall_raw = (d_req & ~r_d_done) | (i_req & ~r_i_done);
   assign stall       = reset_n & w_stall_raw;

   // Slot advance: the core moves on at this edge, so the served flags clear.
   assign w_advance = ~w_stall_raw & (r_d_done | r_i_done);

   // A response only counts if it still belongs to the slot that issued it.
   assign w_keep = w_done & ~r_discard & ~w_advance;

   // ---------------------------------------------------------------- FSM ----
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values, independent of statement order between blocks.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      w_start_d    = 1'b0;
      w_start_i    = 1'b0;
      case (r_state)
         IDLE: begin
            if (d_req && !r_d_done) begin
               w_next_state = D_BUS;
               w_start_d    = 1'b1;
            end else if (i_req && !r_i_done) begin
               w_next_state = I_BUS;
               w_start_i    = 1'b1;
            end
         end
         D_BUS, I_BUS: begin
            if (wb_ack_i || w_timeout) w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // ------------------------------------------------ request / response ----
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_d_done  <= 1'b0;
         r_i_done  <= 1'b0;
         r_discard <= 1'b0;
         r_we      <= 1'b0;
         r_sel     <= '0;
         r_adr     <= '0;
         r_dat     <= '0;
         r_ld_op   <= F3_W;
         r_ld_lo   <= 2'b00;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
      end else begin
         // Bus outputs are latched once at issue and held until completion.
         if (w_start_d) begin
            r_adr     <= word_align(d_addr);
            r_we      <= d_we;
            r_sel     <= w_sel;
            r_dat     <= d_we ? w_st_data : '0;
            r_ld_op   <= d_op;
            r_ld_lo   <= d_addr[1:0];
            r_discard <= 1'b0;
         end else if (w_start_i) begin
            r_adr     <= word_align(i_addr);
            r_we      <= 1'b0;
            r_sel     <= '1;
            r_dat     <= '0;
            r_discard <= 1'b0;
         end else if (w_busy && w_advance) begin
            r_discard <= 1'b1;
         end

         if (w_advance) begin
            r_d_done <= 1'b0;
            r_i_done <= 1'b0;
         end else if (w_keep) begin
            if (r_state == D_BUS) r_d_done <= 1'b1;
            else                  r_i_done <= 1'b1;
         end

         if (w_keep && r_state == D_BUS && !r_we)
            r_d_rdata <= w_timeout ? '0 : w_ld_data;
         if (w_keep && r_state == I_BUS)
            r_i_rdata <= w_timeout ? '0 : wb_dat_i;
      end
   end

   // ------------------------------------------------------------ timeout ----
`ifdef ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             r_bus_err;

   // Counter is zero in the first bus cycle, so the abort edge ends cycle
   // number TIMEOUT_CYCLES of the transaction.
   assign w_timeout = w_busy & ~wb_ack_i & (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tmo_cnt <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_tmo_cnt <= w_busy ? r_tmo_cnt + 1'b1 : '0;
         r_bus_err <= w_timeout;
      end
   end

   assign bus_err = r_bus_err;
`else
   logic w_unused_tmo;

   assign w_timeout    = 1'b0;
   assign bus_err      = 1'b0;
   assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

   // ------------------------------------------------------------ outputs ----
   assign wb_cyc_o = w_busy;
   assign wb_stb_o = w_busy;
   assign wb_we_o  = r_we;
   assign wb_sel_o = r_sel;
   assign wb_adr_o = r_adr;
   assign wb_dat_o = r_dat;
   assign i_rdata  = r_i_rdata;
   assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Scoreboarded bench: each slot pushes the bus transactions it expects and the
// results it expects; a Wishbone slave model pops and checks transactions when
// it acks them, and the slot task pops results once stall drops.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        reset_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [2:0]  d_op;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        stall;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic        bus_err;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_req    (i_req),
      .i_addr   (i_addr),
      .i_rdata  (i_rdata),
      .d_req    (d_req),
      .d_we     (d_we),
      .d_op     (d_op),
      .d_addr   (d_addr),
      .d_wdata  (d_wdata),
      .d_rdata  (d_rdata),
      .stall    (stall),
      .wb_cyc_o (wb_cyc_o),
      .wb_stb_o (wb_stb_o),
      .wb_we_o  (wb_we_o),
      .wb_sel_o (wb_sel_o),
      .wb_adr_o (wb_adr_o),
      .wb_dat_o (wb_dat_o),
      .wb_dat_i (wb_dat_i),
      .wb_ack_i (wb_ack_i),
      .bus_err  (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic        we;
      logic [31:0] dat;
      logic        chk_sel;
      logic        chk_dat;
      logic [31:0] rdata;
   } bus_txn_t;

   typedef struct {
      logic        is_d;
      logic [31:0] val;
   } res_t;

   bus_txn_t bus_q[$];
   res_t     res_q[$];

   int n_tests    = 0;
   int n_fail     = 0;
   int err_seen   = 0;
   int slave_wait = 0;
   bit slave_en   = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   always @(negedge clk) if (bus_err === 1'b1) err_seen++;

   // Wishbone slave: acks after slave_wait extra cycles, checking the popped
   // transaction against what the DUT presents at that moment.
   initial begin
      int wcnt;
      bus_txn_t t;
      wcnt     = 0;
      wb_ack_i = 1'b0;
      wb_dat_i = '0;
      forever begin
         @(posedge clk);
         #1;
         if (slave_en) begin
            if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
               if (wcnt >= slave_wait) begin
                  check("bus_expected", 32'(bus_q.size() > 0), 32'd1);
                  if (bus_q.size() > 0) begin
                     t = bus_q.pop_front();
                     check("bus_adr", wb_adr_o, t.adr);
                     check("bus_we", 32'(wb_we_o), 32'(t.we));
                     if (t.chk_sel) check("bus_sel", 32'(wb_sel_o), 32'(t.sel));
                     if (t.chk_dat) check("bus_dat", wb_dat_o, t.dat);
                     wb_dat_i = t.rdata;
                  end
                  wb_ack_i = 1'b1;
                  wcnt     = 0;
               end else begin
                  wcnt++;
               end
            end else begin
               wb_ack_i = 1'b0;
               if (!wb_cyc_o) wcnt = 0;
            end
         end
      end
   end

   // One pipeline slot: optional data access plus optional fetch.
   task automatic slot(input string tag,
                       input logic dq, input logic we, input logic [2:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] raw, input logic [3:0] esel,
                       input logic [31:0] eadr, input logic [31:0] edat,
                       input logic [31:0] ed,
                       input logic iq, input logic [31:0] ia, input logic [31:0] iraw,
                       input int estall);
      int stalled;
      res_t r;
      if (dq) begin
         bus_q.push_back('{eadr, esel, we, edat, we, we, raw});
         res_q.push_back('{1'b1, ed});
      end
      if (iq) begin
         bus_q.push_back('{ia, 4'b1111, 1'b0, 32'h0, 1'b1, 1'b0, iraw});
         res_q.push_back('{1'b0, iraw});
      end
      @(posedge clk);
      #1;
      d_req = dq; d_we = we; d_op = op; d_addr = addr; d_wdata = wdata;
      i_req = iq; i_addr = ia;
      stalled = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!stall) break;
         stalled++;
      end
      check({tag, "_stall_release"}, 32'(stall), 32'd0);
      check({tag, "_stall_cycles"}, stalled, estall);
      while (res_q.size() > 0) begin
         r = res_q.pop_front();
         if (r.is_d) check({tag, "_d_rdata"}, d_rdata, r.val);
         else        check({tag, "_i_rdata"}, i_rdata, r.val);
      end
      check({tag, "_bus_drained"}, bus_q.size(), 0);
      @(posedge clk);
      #1;
      d_req = 1'b0;
      i_req = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      int cyc_cnt;
      int err0;

      reset_n = 1'b0;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_op = F3_W; d_addr = '0; d_wdata = '0;
      #3;
      check("rst_cyc", 32'(wb_cyc_o), 32'd0);
      check("rst_stb", 32'(wb_stb_o), 32'd0);
      check("rst_we", 32'(wb_we_o), 32'd0);
      check("rst_sel", 32'(wb_sel_o), 32'd0);
      check("rst_adr", wb_adr_o, 32'h0);
      check("rst_dat", wb_dat_o, 32'h0);
      check("rst_i_rdata", i_rdata, 32'h0);
      check("rst_d_rdata", d_rdata, 32'h0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (2) @(posedge clk);

      // Simultaneous data + fetch: data first, four stall cycles.
      slot("dual", 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h100, 32'h0,
           32'hDEADBEEF, 1, 32'h40, 32'h00500093, 4);
      // Stores: lane select and replication; d_rdata holds the last load.
      slot("sb", 1, 1, F3_B, 32'h203, 32'hA5, 32'h0, 4'b1000, 32'h200, 32'hA5A5A5A5,
           32'hDEADBEEF, 0, 32'h0, 32'h0, 2);
      // Loads: lane extraction with sign / zero extension.
      slot("lb", 1, 0, F3_B, 32'h302, 32'h0, 32'h00800000, 4'b0, 32'h300, 32'h0,
           32'hFFFFFF80, 0, 32'h0, 32'h0, 2);
      slot("lbu", 1, 0, F3_BU, 32'h302, 32'h0, 32'h00800000, 4'b0, 32'h300, 32'h0,
           32'h00000080, 0, 32'h0, 32'h0, 2);
      slot("lh", 1, 0, F3_H, 32'h102, 32'h0, 32'h80010000, 4'b0, 32'h100, 32'h0,
           32'hFFFF8001, 0, 32'h0, 32'h0, 2);
      slot("lhu", 1, 0, F3_HU, 32'h102, 32'h0, 32'h80010000, 4'b0, 32'h100, 32'h0,
           32'h00008001, 0, 32'h0, 32'h0, 2);
      slot("lb_pos", 1, 0, F3_B, 32'h303, 32'h0, 32'h7F000000, 4'b0, 32'h300, 32'h0,
           32'h0000007F, 0, 32'h0, 32'h0, 2);
      slot("sh", 1, 1, F3_H, 32'h106, 32'h1234BEEF, 32'h0, 4'b1100, 32'h104, 32'hBEEFBEEF,
           32'h0000007F, 0, 32'h0, 32'h0, 2);
      slot("sw", 1, 1, F3_W, 32'h10C, 32'hCAFEF00D, 32'h0, 4'b1111, 32'h10C, 32'hCAFEF00D,
           32'h0000007F, 0, 32'h0, 32'h0, 2);
      // Misaligned word store: word address, select truncated to 1110.
      slot("sw_mis", 1, 1, F3_W, 32'h10D, 32'hCAFEF00D, 32'h0, 4'b1110, 32'h10C, 32'hCAFEF00D,
           32'h0000007F, 0, 32'h0, 32'h0, 2);
      // Fetch with a slow slave: three wait cycles before ack.
      slave_wait = 3;
      slot("fetch_wait", 0, 0, F3_W, 32'h0, 32'h0, 32'h0, 4'b0, 32'h0, 32'h0,
           32'h0, 1, 32'h44, 32'h00A00113, 5);

      // Request withdrawn mid-transaction: the access still completes.
      slave_wait = 2;
      bus_q.push_back('{32'h500, 4'b1111, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0BADF00D});
      @(posedge clk);
      #1 d_req = 1'b1; d_we = 1'b0; d_op = F3_W; d_addr = 32'h500;
      @(posedge clk);
      #1 d_req = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!wb_cyc_o && bus_q.size() == 0) break;
      end
      check("drop_bus_drained", bus_q.size(), 0);
      check("drop_d_rdata", d_rdata, 32'h0BADF00D);
      check("drop_stall", 32'(stall), 32'd0);
      slave_wait = 0;
      repeat (2) @(posedge clk);

`ifdef ARB_TIMEOUT_EN
      // No ack at all: abort after 16 bus cycles with a zero result.
      slave_en = 1'b0;
      err0     = err_seen;
      seen     = 1'b0;
      cyc_cnt  = 0;
      @(posedge clk);
      #1 d_req = 1'b1; d_we = 1'b0; d_op = F3_W; d_addr = 32'h400;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (wb_cyc_o) begin
            seen = 1'b1;
            cyc_cnt++;
         end else if (seen) begin
            break;
         end
      end
      check("tmo_cyc_cycles", cyc_cnt, 16);
      check("tmo_bus_err", 32'(bus_err), 32'd1);
      check("tmo_stall", 32'(stall), 32'd0);
      check("tmo_d_rdata", d_rdata, 32'h0);
      @(posedge clk);
      #1 d_req = 1'b0;
      @(negedge clk);
      check("tmo_bus_err_pulse", 32'(bus_err), 32'd0);
      check("tmo_err_count", err_seen - err0, 1);
      slave_en = 1'b1;
      repeat (2) @(posedge clk);
`else
      err0    = 0;
      seen    = 1'b0;
      cyc_cnt = 0;
`endif

      // Reset while a fetch is on the bus; a late ack must be ignored.
      slave_en = 1'b0;
      @(posedge clk);
      #1 i_req = 1'b1; i_addr = 32'h80;
      @(negedge clk);
      @(negedge clk);
      check("rstbus_pre_cyc", 32'(wb_cyc_o), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("rstbus_cyc", 32'(wb_cyc_o), 32'd0);
      check("rstbus_stb", 32'(wb_stb_o), 32'd0);
      check("rstbus_stall", 32'(stall), 32'd0);
      check("rstbus_i_rdata", i_rdata, 32'h0);
      i_req = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      wb_ack_i = 1'b1;
      wb_dat_i = 32'h12345678;
      repeat (2) begin
         @(negedge clk);
         check("rstbus_late_cyc", 32'(wb_cyc_o), 32'd0);
         check("rstbus_late_i_rdata", i_rdata, 32'h0);
      end
      @(posedge clk);
      #1 wb_ack_i = 1'b0;
      slave_en = 1'b1;

`ifndef ARB_TIMEOUT_EN
      check("bus_err_never", err_seen, 0);
`endif
      check("bus_q_empty", bus_q.size(), 0);
      check("res_q_empty", res_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
